// File: rtl/pfpu_pkg.sv
// Shared PFPU definitions: float constants, op-code encoding and the boolean truth test.
// PFPU_SELECT_NAN_EN makes the truth test treat NaN as false.
package pfpu_pkg;

    localparam logic [31:0] FLOAT_ONE  = 32'h3f800000;
    localparam logic [31:0] FLOAT_ZERO = 32'h00000000;

    typedef enum logic [1:0] {
        OP_PASS = 2'd0,
        OP_SETC = 2'd1,
        OP_SEL  = 2'd2
    } pfpu_op_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        pfpu_op_e    op;
    } pfpu_req_t;

    // SEL wins when both strobes are set; SETC is then silently ignored.
    function automatic pfpu_op_e decode_op(input logic setc, input logic sel);
        if (sel)       return OP_SEL;
        else if (setc) return OP_SETC;
        else           return OP_PASS;
    endfunction

    function automatic logic is_nan(input logic [31:0] f);
        return (f[30:23] == 8'hff) && (f[22:0] != 23'd0);
    endfunction

    function automatic logic truth(input logic [31:0] f);
`ifdef PFPU_SELECT_NAN_EN
        return (f[30:0] != 31'd0) && !is_nan(f);
`else
        return f[30:0] != 31'd0;
`endif
    endfunction

endpackage

// File: rtl/pfpu_condstack.sv
// CDEPTH-entry condition LIFO; a push into a full stack drops the oldest entry.
module pfpu_condstack #(
    parameter  int CDEPTH = 2,
    localparam int CW     = $clog2(CDEPTH + 1)
) (
    input  logic          sys_clk,
    input  logic          alu_rst,
    input  logic          push,
    input  logic          pop,
    input  logic          din,
    output logic          top,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    // Entry 0 is the bottom; the top lives at index count-1.
    logic [CDEPTH-1:0] stk;

    assign empty = (count == '0);
    assign full  = (count == CW'(CDEPTH));

    always_comb begin
        top = 1'b0;
        for (int i = 0; i < CDEPTH; i++)
            if (count == CW'(i + 1)) top = stk[i];
    end

    always_ff @(posedge sys_clk or posedge alu_rst) begin
        if (alu_rst) begin
            stk   <= '0;
            count <= '0;
        end else if (push) begin
            if (full) begin
                for (int i = 0; i < CDEPTH - 1; i++) stk[i] <= stk[i + 1];
                stk[CDEPTH-1] <= din;
            end else begin
                for (int i = 0; i < CDEPTH; i++)
                    if (count == CW'(i)) stk[i] <= din;
                count <= count + CW'(1);
            end
        end else if (pop && !empty) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/pfpu_select.sv
// PFPU select unit: SETC pushes a float-derived condition, SEL pops it to choose a or b.
// PFPU_SELECT_NAN_EN: NaN tests false and the sticky nan_seen output is added.
module pfpu_select
    import pfpu_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int CDEPTH  = 2
) (
    input  logic        sys_clk,
    input  logic        alu_rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op_setc,
    input  logic        op_sel,
    input  logic        valid_i,
    output logic [31:0] r,
    output logic        valid_o,
    output logic        underflow,
`ifdef PFPU_SELECT_NAN_EN
    output logic        overflow,
    output logic        nan_seen
`else
    output logic        overflow
`endif
);

    localparam int CW = $clog2(CDEPTH + 1);

    pfpu_req_t     req;
    logic          acc_setc, acc_sel, cond;
    logic          st_top, st_empty, st_full;
    logic [CW-1:0] st_count;
    logic [31:0]   res0;

    logic [LATENCY-1:0] vld_pipe;
    logic [31:0]        res_pipe [LATENCY-1:0];

    assign req      = '{a: a, b: b, op: decode_op(op_setc, op_sel)};
    assign acc_setc = valid_i && (req.op == OP_SETC);
    assign acc_sel  = valid_i && (req.op == OP_SEL);
    assign cond     = truth(req.a);

    // Stack updates in the accept cycle so an immediately following SEL sees the push.
    pfpu_condstack #(.CDEPTH(CDEPTH)) u_stack (
        .sys_clk (sys_clk),
        .alu_rst (alu_rst),
        .push    (acc_setc),
        .pop     (acc_sel),
        .din     (cond),
        .top     (st_top),
        .count   (st_count),
        .empty   (st_empty),
        .full    (st_full)
    );

    always_comb begin
        assert (st_count <= CW'(CDEPTH));
    end

    always_comb begin
        res0 = req.a;
        case (req.op)
            OP_SETC: res0 = cond ? FLOAT_ONE : FLOAT_ZERO;
            OP_SEL:  res0 = (!st_empty && st_top) ? req.a : req.b;
            default: res0 = req.a;
        endcase
    end

    // Data advances only with its valid bit, so r holds between results.
    always_ff @(posedge sys_clk or posedge alu_rst) begin
        if (alu_rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < LATENCY; i++) res_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= valid_i;
            if (valid_i) res_pipe[0] <= res0;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1]) res_pipe[i] <= res_pipe[i-1];
            end
        end
    end

    assign valid_o = vld_pipe[LATENCY-1];
    assign r       = res_pipe[LATENCY-1];

    always_ff @(posedge sys_clk or posedge alu_rst) begin
        if (alu_rst) begin
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (acc_sel && st_empty) underflow <= 1'b1;
            if (acc_setc && st_full) overflow  <= 1'b1;
        end
    end

`ifdef PFPU_SELECT_NAN_EN
    always_ff @(posedge sys_clk or posedge alu_rst) begin
        if (alu_rst)                        nan_seen <= 1'b0;
        else if (acc_setc && is_nan(req.a)) nan_seen <= 1'b1;
    end
`endif

endmodule
